// File: rtl/dly_pkg.sv
// Shared sizing defaults and helpers for the delay-tap value select path.
package dly_pkg;

    localparam int unsigned NUM_DLY_DEF = 20;
    localparam int unsigned DLY_W_DEF   = 6;
    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned MAX_DLY     = 32;

    // Extract lane i from a bank sized with the default geometry.
    function automatic logic [DLY_W_DEF-1:0] get_entry(
        input logic [NUM_DLY_DEF*DLY_W_DEF-1:0] bank,
        input int unsigned                       idx
    );
        logic [DLY_W_DEF-1:0] entry;
        entry = '0;
        if (idx < NUM_DLY_DEF) begin
            entry = bank[idx*DLY_W_DEF +: DLY_W_DEF];
        end
        return entry;
    endfunction

endpackage

// File: rtl/dly_sel_comb.sv
// Range-checked combinational select of one lane from the packed tap bank.
module dly_sel_comb
    import dly_pkg::*;
#(
    parameter int unsigned NUM_DLY = NUM_DLY_DEF,
    parameter int unsigned DLY_W   = DLY_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic [NUM_DLY*DLY_W-1:0] bank,
    input  logic [ADDR_W-1:0]        addr,
    output logic [DLY_W-1:0]         sel_c
);

    localparam int unsigned IDX_W = (NUM_DLY > 1) ? $clog2(NUM_DLY) : 1;
    localparam int unsigned CMP_W = ADDR_W + 1;

    logic [DLY_W-1:0] entries [NUM_DLY];
    logic [IDX_W-1:0] idx;
    logic             in_range;

    for (genvar i = 0; i < NUM_DLY; i++) begin : g_unpack
        assign entries[i] = bank[i*DLY_W +: DLY_W];
    end

    assign idx      = IDX_W'(addr);
    assign in_range = ({1'b0, addr} < CMP_W'(NUM_DLY));

    // An unknown address makes in_range unknown, which falls to the zero branch.
    always_comb begin
        sel_c = '0;
        if (in_range) begin
            sel_c = entries[idx];
        end
    end

endmodule

// File: rtl/dly_value_mux.sv
// Registered readback of one per-lane delay-tap value; unpopulated lanes read as zero.
module dly_value_mux
    import dly_pkg::*;
#(
    parameter int unsigned NUM_DLY = NUM_DLY_DEF,
    parameter int unsigned DLY_W   = DLY_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_DLY*DLY_W-1:0] DLY_TAP_VAL_ARRAY,
    input  logic [ADDR_W-1:0]        DLY_ADDR,
    output logic [DLY_W-1:0]         DLY_TAP_VALUE
);

    if ((NUM_DLY < 1) || (NUM_DLY > MAX_DLY) ||
        ((64'd1 << ADDR_W) < 64'(NUM_DLY))) begin : g_param_chk
        $fatal(1, "dly_value_mux: NUM_DLY must be 1..32 and fit in 2**ADDR_W");
    end

    logic [DLY_W-1:0] sel_c;

    dly_sel_comb #(
        .NUM_DLY (NUM_DLY),
        .DLY_W   (DLY_W),
        .ADDR_W  (ADDR_W)
    ) u_sel (
        .bank    (DLY_TAP_VAL_ARRAY),
        .addr    (DLY_ADDR),
        .sel_c   (sel_c)
    );

    // Single output stage; reset discards any pending selection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DLY_TAP_VALUE <= '0;
        end else begin
            DLY_TAP_VALUE <= sel_c;
        end
    end

endmodule

// File: tb/tb_dly_value_mux.sv
// Scoreboard bench for dly_value_mux: expected values queued at drive, checked after the edge.
module tb_dly_value_mux;

    localparam int unsigned NUM = 20;
    localparam int unsigned W   = 6;
    localparam int unsigned AW  = 5;

    logic              CLK;
    logic              RST;
    logic [NUM*W-1:0]  DLY_TAP_VAL_ARRAY;
    logic [AW-1:0]     DLY_ADDR;
    logic [W-1:0]      DLY_TAP_VALUE;

    logic [W-1:0]      bank_m [NUM];
    logic [W-1:0]      exp_q [$];
    logic [W-1:0]      last_exp;
    logic              have_last;
    int                vec_cnt;
    int                err_cnt;

    dly_value_mux #(
        .NUM_DLY           (NUM),
        .DLY_W             (W),
        .ADDR_W            (AW)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .DLY_TAP_VAL_ARRAY (DLY_TAP_VAL_ARRAY),
        .DLY_ADDR          (DLY_ADDR),
        .DLY_TAP_VALUE     (DLY_TAP_VALUE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, confirm the output has not moved early, then check after the edge.
    task automatic apply(input string tag, input logic rst, input logic [AW-1:0] addr);
        logic [W-1:0] exp;
        RST      = rst;
        DLY_ADDR = addr;
        for (int i = 0; i < NUM; i++) begin
            DLY_TAP_VAL_ARRAY[i*W +: W] = bank_m[i];
        end
        if (rst) begin
            exp = '0;
        end else if (int'(addr) < NUM) begin
            exp = bank_m[int'(addr)];
        end else begin
            exp = '0;
        end
        exp_q.push_back(exp);
        #1;
        if (have_last) begin
            check_val({tag, "_hold"}, DLY_TAP_VALUE, last_exp);
        end
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, DLY_TAP_VALUE, exp);
        end else begin
            check_val(tag, DLY_TAP_VALUE, exp_q.pop_front());
        end
        last_exp  = exp;
        have_last = 1'b1;
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        have_last = 1'b0;
        last_exp  = '0;
        RST       = 1'b1;
        DLY_ADDR  = '0;
        DLY_TAP_VAL_ARRAY = '0;
        for (int i = 0; i < NUM; i++) bank_m[i] = '0;

        // Reset held three cycles, then first live value.
        bank_m[0] = 6'h2A;
        for (int c = 0; c < 3; c++) apply("reset", 1'b1, 5'd0);
        apply("reset_release", 1'b0, 5'd0);

        // In-range sweep with entry i = i+1.
        for (int i = 0; i < NUM; i++) bank_m[i] = W'(i + 1);
        for (int a = 0; a < NUM; a++) apply("sweep", 1'b0, AW'(a));

        // Out-of-range addresses read zero even with a full bank.
        for (int i = 0; i < NUM; i++) bank_m[i] = 6'h3F;
        apply("oor_pre", 1'b0, 5'd4);
        apply("oor_20", 1'b0, 5'd20);
        apply("oor_pre", 1'b0, 5'd19);
        apply("oor_25", 1'b0, 5'd25);
        apply("oor_pre", 1'b0, 5'd0);
        apply("oor_31", 1'b0, 5'd31);

        // Random bank and addresses, each held several cycles.
        for (int i = 0; i < NUM; i++) bank_m[i] = W'($urandom_range(0, 63));
        for (int r = 0; r < 10; r++) begin
            logic [AW-1:0] ra;
            ra = AW'($urandom_range(0, 31));
            for (int c = 0; c < 10; c++) apply("random", 1'b0, ra);
        end

        // Data update on the selected lane versus a neighbouring lane.
        bank_m[7] = 6'h05;
        bank_m[8] = 6'h11;
        apply("data_init", 1'b0, 5'd7);
        bank_m[7] = 6'h31;
        apply("data_upd7", 1'b0, 5'd7);
        bank_m[8] = 6'h22;
        apply("data_upd8", 1'b0, 5'd7);

        // Address and data changing together.
        bank_m[12] = 6'h1C;
        apply("addr_data", 1'b0, 5'd12);

        // Reset pulse mid-stream.
        bank_m[3] = 6'h12;
        apply("mid_pre", 1'b0, 5'd3);
        apply("mid_rst", 1'b1, 5'd3);
        apply("mid_post", 1'b0, 5'd3);
        apply("mid_hold", 1'b0, 5'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
